mem_resp: RTL
=============

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter mem_base, default 32'h8000_0000, meaning byte base address of the backing RAM.
REQ-002 SHALL have parameter mem_depth, default 1024, meaning RAM size in 32-bit words (power of two).
REQ-003 SHALL have parameter mem_latency, default 2, meaning cycles from request-valid cycle to its mem_ready cycle (range 1..15).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port dmem_in  input  mem_in_type  request (mem_valid, mem_fence, mem_instr, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]).
REQ-007 SHALL have port dmem_out  output  mem_out_type  response (mem_rdata[31:0], mem_ready).
REQ-008 SHALL have port err  output  1  sticky flag: dropped request or out-of-range access.

Function
REQ-009 SHALL treat mem_valid as a single-cycle request pulse; the request SHALL be captured in the cycle mem_valid=1, with no requirement that the initiator hold it.
REQ-010 SHALL implement states IDLE, WAIT, RESP; IDLE->WAIT on capture (mem_latency>1), IDLE->RESP on capture (mem_latency=1), WAIT->RESP when the latency counter reaches mem_latency-1, RESP->IDLE if no request is pending, RESP->WAIT/RESP if one is.
REQ-011 SHALL assert mem_ready for exactly one cycle, mem_latency cycles after the capture cycle of an uncontended request.
REQ-012 SHALL derive word index from mem_addr[2+log2(mem_depth)-1:2]; mem_addr[1:0] ignored.
REQ-013 SHALL classify an access in range when mem_base <= mem_addr < mem_base+4*mem_depth, using unsigned 32-bit compare.
REQ-014 Read (mem_wstrb=0, in range): mem_rdata SHALL equal the stored word in the mem_ready cycle.
REQ-015 Write (mem_wstrb!=0, in range): SHALL update only bytes whose strobe bit is 1, committed at the clock edge ending the mem_ready cycle; mem_rdata SHALL be the pre-write word.
REQ-016 Fence (mem_fence=1): SHALL perform no RAM access and respond with mem_rdata=0 after mem_latency cycles.
REQ-017 Out-of-range: SHALL suppress the write, respond with mem_rdata=0 at normal latency, and set err.
REQ-018 mem_rdata SHALL be 0 in every cycle mem_ready=0.
REQ-019 mem_instr SHALL be ignored functionally.
REQ-020 SHALL hold one active request plus a one-entry pending buffer; a request captured while active SHALL go to pending.
REQ-021 In the mem_ready cycle, pending (if valid) SHALL become active with latency counter restarted; its mem_ready follows mem_latency cycles later.
REQ-022 A request arriving in a mem_ready cycle SHALL be accepted: into active if pending is empty, otherwise into pending while the old pending moves to active.
REQ-023 A request arriving while active and pending are both occupied, outside a mem_ready cycle, SHALL be dropped with no response and SHALL set err.
REQ-024 Requests SHALL be answered strictly in arrival order.
REQ-025 err SHALL stay 1 until reset.

Reset
REQ-026 While reset=0 at a clock edge: state IDLE, counter 0, active and pending invalid, mem_ready=0, mem_rdata=0, err=0.
REQ-027 Reset mid-operation SHALL discard active and pending requests without committing any write and without a later mem_ready.
REQ-028 RAM contents SHALL not be cleared by reset.

Verification
REQ-029 Latency 2: write 0xDEADBEEF strb 0xF to 0x8000_0010 at cycle T -> mem_ready at T+2, rdata = old word; read at T+5 -> ready T+7, rdata 0xDEADBEEF.
REQ-030 Partial write strb 0x6, wdata 0x11223344 over 0xDEADBEEF -> subsequent read returns 0xDE2233EF.
REQ-031 Read 0x7FFF_FFFC and write 0x8000_1000 (depth 1024) -> rdata 0, RAM unchanged, err=1.
REQ-032 Latency 3: requests A,B at T,T+1, C at T+2 -> ready T+3 (A), T+6 (B); C dropped, err=1; request D at T+3 accepted and answered at T+9.
REQ-033 Fence at T with latency 1 -> mem_ready at T+1, rdata 0, no RAM change.
REQ-034 Write captured at T, reset=0 at T+1 -> no mem_ready, target word unchanged, err=0.

Source files
------------

// File: rtl/mem_resp.sv
// Latency-configurable RAM responder: one active request plus one pending slot, in-order responses.
// dmem_in packs {mem_valid, mem_fence, mem_instr, mem_addr, mem_wdata, mem_wstrb}; dmem_out packs {mem_rdata, mem_ready}.
module mem_resp #(
  parameter logic [31:0] mem_base    = 32'h8000_0000,
  parameter int unsigned mem_depth   = 1024,
  parameter int unsigned mem_latency = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [70:0] dmem_in,
  output logic [32:0] dmem_out,
  output logic        err
);

  localparam int unsigned AW    = $clog2(mem_depth);
  localparam logic [32:0] LIMIT = {1'b0, mem_base} + (33'(mem_depth) * 33'd4);
  localparam logic [3:0]  LAST  = 4'(mem_latency - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        fence;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  localparam state_t START = (mem_latency == 1) ? S_RESP : S_WAIT;

  logic        w_valid;
  logic        w_instr;
  logic        w_unused;
  req_t        w_req;

  assign w_valid      = dmem_in[70];
  assign w_req.fence  = dmem_in[69];
  assign w_instr      = dmem_in[68];
  assign w_req.addr   = dmem_in[67:36];
  assign w_req.wdata  = dmem_in[35:4];
  assign w_req.wstrb  = dmem_in[3:0];
  assign w_unused     = w_instr;

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nx;

  logic        r_act_valid;
  req_t        r_act;
  logic        r_pnd_valid;
  req_t        r_pnd;
  logic        r_err;

  logic [31:0] r_mem [mem_depth];

  logic          w_resp;
  logic          w_in_range;
  logic          w_act_ok;
  logic          w_commit;
  logic          w_range_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;

  assign w_resp      = (r_state == S_RESP);
  assign w_in_range  = ({1'b0, r_act.addr} >= {1'b0, mem_base}) && ({1'b0, r_act.addr} < LIMIT);
  assign w_act_ok    = r_act_valid && !r_act.fence && w_in_range;
  assign w_range_err = w_resp && r_act_valid && !r_act.fence && !w_in_range;
  assign w_idx       = r_act.addr[AW+1:2];
  assign w_commit    = reset && w_resp && w_act_ok && (r_act.wstrb != 4'd0);

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_state_nx = START;
          w_cnt_nx   = 4'd1;
        end
      end
      S_WAIT: begin
        if (r_cnt == LAST) begin
          w_state_nx = S_RESP;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt + 4'd1;
        end
      end
      S_RESP: begin
        if (r_pnd_valid || w_valid) begin
          w_state_nx = START;
          w_cnt_nx   = 4'd1;
        end else begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------- request slots ----------------
  // In the response cycle the pending entry is promoted first, so a new arrival
  // lands behind it and arrival order is kept.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_act_valid <= 1'b0;
      r_pnd_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_range_err) begin
        r_err <= 1'b1;
      end
      if (w_resp) begin
        if (r_pnd_valid) begin
          r_act       <= r_pnd;
          r_act_valid <= 1'b1;
          r_pnd_valid <= w_valid;
          if (w_valid) begin
            r_pnd <= w_req;
          end
        end else begin
          r_act_valid <= w_valid;
          if (w_valid) begin
            r_act <= w_req;
          end
        end
      end else if (!r_act_valid) begin
        if (w_valid) begin
          r_act       <= w_req;
          r_act_valid <= 1'b1;
        end
      end else if (w_valid) begin
        if (!r_pnd_valid) begin
          r_pnd       <= w_req;
          r_pnd_valid <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // ---------------- RAM (not cleared by reset) ----------------
  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (r_act.wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= r_act.wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_resp && w_act_ok) begin
      w_rdata = r_mem[w_idx];
    end
  end

  assign dmem_out = {w_rdata, w_resp};
  assign err      = r_err;

endmodule
